// File: rtl/vram_line_fetch_arbiter.sv
// vram_line_fetch_arbiter
//
// Shares one single-port video RAM between CPU accesses and the display line
// prefetch. A fixed number of clocks before each displayed row goes active,
// the row's words are copied from VRAM into the display line buffer; outside
// that window the CPU gets the memory. A missed deadline is flagged.
//
// Ports:
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_pix_stb               one-cycle pixel strobe from the video generator
//   i_clks_before_active    signed pixels until active video on this line
//   i_y                     current row from the video generator
//   i_cpu_req/we/addr/wdata CPU request, held until o_cpu_ack
//   o_cpu_ack, o_cpu_rdata  CPU completion (combinational from i_mem_ack)
//   o_mem_req/we/addr/wdata memory request, held stable until i_mem_ack
//   i_mem_ack, i_mem_rdata  memory completion, read data valid with the ack
//   o_lb_we/addr/wdata      line buffer write port
//   o_line_ready            line buffer holds the complete current row
//   o_underrun              one-cycle pulse when the fetch deadline is missed
//   o_dbg_state             arbiter FSM state (0 ARB, 1 CPU_XFER, 2 FETCH_XFER)
//
// Handshakes: a request (i_cpu_req / o_mem_req) is raised with its command
// fields and held unchanged until the matching one-cycle ack; the transfer
// completes in the ack cycle and the requester may drop or replace the
// request in the following cycle.

module vram_line_fetch_arbiter #(
    parameter int ADDR_W         = 15,
    parameter int SCREEN_BASE    = 16384,
    parameter int WORDS_PER_LINE = 32,
    parameter int V_ROWS         = 256,
    parameter int FETCH_LEAD     = 100
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                i_pix_stb,
    input  logic signed [9:0]                   i_clks_before_active,
    input  logic [9:0]                          i_y,
    input  logic                                i_cpu_req,
    input  logic                                i_cpu_we,
    input  logic [ADDR_W-1:0]                   i_cpu_addr,
    input  logic [15:0]                         i_cpu_wdata,
    output logic                                o_cpu_ack,
    output logic [15:0]                         o_cpu_rdata,
    output logic                                o_mem_req,
    output logic                                o_mem_we,
    output logic [ADDR_W-1:0]                   o_mem_addr,
    output logic [15:0]                         o_mem_wdata,
    input  logic                                i_mem_ack,
    input  logic [15:0]                         i_mem_rdata,
    output logic                                o_lb_we,
    output logic [$clog2(WORDS_PER_LINE)-1:0]   o_lb_addr,
    output logic [15:0]                         o_lb_wdata,
    output logic                                o_line_ready,
    output logic                                o_underrun,
    output logic [1:0]                          o_dbg_state
);

    localparam int LB_W = $clog2(WORDS_PER_LINE);
    localparam logic signed [9:0] LEAD_S = 10'(FETCH_LEAD);
    localparam logic [9:0]        Y_LIM  = 10'(V_ROWS);

    typedef enum logic [1:0] {
        ST_ARB        = 2'd0,
        ST_CPU_XFER   = 2'd1,
        ST_FETCH_XFER = 2'd2
    } state_t;

    state_t            r_state;
    logic [9:0]        r_row;
    logic [LB_W-1:0]   r_word_idx;
    logic              r_fetch_pending;
    logic              r_stale;       // in-flight fetch belongs to an abandoned row
    logic              r_final_wr;    // last word is being written this cycle

    logic              w_trigger;
    logic              w_deadline;
    logic              w_word_ok;
    logic              w_last_word;
    logic [ADDR_W-1:0] w_fetch_addr;

    assign w_trigger   = i_pix_stb && (i_clks_before_active == LEAD_S) && (i_y < Y_LIM);
    assign w_deadline  = i_pix_stb && (i_clks_before_active == 10'sd0) && r_fetch_pending;
    assign w_last_word = (r_word_idx == LB_W'(WORDS_PER_LINE - 1));

    // A fetch ack is only kept while the row is still wanted: the deadline
    // may have dropped it, or a new trigger may have retargeted the fetch.
    assign w_word_ok = (r_state == ST_FETCH_XFER) && i_mem_ack && r_fetch_pending
                       && !r_stale && !w_trigger;

    assign w_fetch_addr = ADDR_W'(SCREEN_BASE + 32'(r_row) * WORDS_PER_LINE + 32'(r_word_idx));

    assign o_cpu_ack   = i_mem_ack && (r_state == ST_CPU_XFER);
    assign o_cpu_rdata = i_mem_rdata;
    assign o_dbg_state = r_state;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state         <= ST_ARB;
            o_mem_req       <= 1'b0;
            o_mem_we        <= 1'b0;
            o_mem_addr      <= '0;
            o_mem_wdata     <= '0;
            o_lb_we         <= 1'b0;
            o_lb_addr       <= '0;
            o_lb_wdata      <= '0;
            o_line_ready    <= 1'b0;
            o_underrun      <= 1'b0;
            r_row           <= '0;
            r_word_idx      <= '0;
            r_fetch_pending <= 1'b0;
            r_stale         <= 1'b0;
            r_final_wr      <= 1'b0;
        end else begin
            o_lb_we    <= 1'b0;
            o_underrun <= 1'b0;
            r_final_wr <= 1'b0;

            case (r_state)
                ST_ARB: begin
                    // A trigger seen this cycle holds the arbiter here so the
                    // freshly latched row wins over a CPU request of the same cycle.
                    if (!w_trigger) begin
                        if (r_fetch_pending) begin
                            r_state    <= ST_FETCH_XFER;
                            o_mem_req  <= 1'b1;
                            o_mem_we   <= 1'b0;
                            o_mem_addr <= w_fetch_addr;
                            r_stale    <= 1'b0;
                        end else if (i_cpu_req && !o_cpu_ack) begin
                            r_state     <= ST_CPU_XFER;
                            o_mem_req   <= 1'b1;
                            o_mem_we    <= i_cpu_we;
                            o_mem_addr  <= i_cpu_addr;
                            o_mem_wdata <= i_cpu_wdata;
                        end
                    end
                end
                ST_CPU_XFER: begin
                    if (i_mem_ack) begin
                        r_state   <= ST_ARB;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                    end
                end
                ST_FETCH_XFER: begin
                    if (i_mem_ack) begin
                        r_state   <= ST_ARB;
                        o_mem_req <= 1'b0;
                        o_mem_we  <= 1'b0;
                    end else if (w_trigger) begin
                        r_stale <= 1'b1;
                    end
                end
                default: begin
                    r_state   <= ST_ARB;
                    o_mem_req <= 1'b0;
                    o_mem_we  <= 1'b0;
                end
            endcase

            if (w_word_ok) begin
                o_lb_we    <= 1'b1;
                o_lb_addr  <= r_word_idx;
                o_lb_wdata <= i_mem_rdata;
                r_word_idx <= r_word_idx + LB_W'(1);
                if (w_last_word) begin
                    r_fetch_pending <= 1'b0;
                    r_final_wr      <= 1'b1;
                end
            end

            if (r_final_wr) begin
                o_line_ready <= 1'b1;
            end

            // The final word landing on the deadline cycle still counts as on time.
            if (w_deadline) begin
                r_fetch_pending <= 1'b0;
                o_underrun      <= !(w_word_ok && w_last_word);
            end

            if (w_trigger) begin
                r_row           <= i_y;
                r_word_idx      <= '0;
                r_fetch_pending <= 1'b1;
                o_line_ready    <= 1'b0;
                r_final_wr      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_vram_line_fetch_arbiter.sv
module tb_vram_line_fetch_arbiter;

    localparam int AW   = 15;
    localparam int BASE = 16384;
    localparam int WPL  = 32;
    localparam int VR   = 256;
    localparam int LEAD = 100;
    localparam int LBW  = $clog2(WPL);
    localparam int EW   = AW + 18;   // {check_wdata, we, addr, wdata}

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic              i_pix_stb = 1'b0;
    logic signed [9:0] i_clks_before_active = '0;
    logic [9:0]        i_y = '0;
    logic              i_cpu_req = 1'b0;
    logic              i_cpu_we = 1'b0;
    logic [AW-1:0]     i_cpu_addr = '0;
    logic [15:0]       i_cpu_wdata = '0;
    logic              o_cpu_ack;
    logic [15:0]       o_cpu_rdata;
    logic              o_mem_req;
    logic              o_mem_we;
    logic [AW-1:0]     o_mem_addr;
    logic [15:0]       o_mem_wdata;
    logic              i_mem_ack = 1'b0;
    logic [15:0]       i_mem_rdata = '0;
    logic              o_lb_we;
    logic [LBW-1:0]    o_lb_addr;
    logic [15:0]       o_lb_wdata;
    logic              o_line_ready;
    logic              o_underrun;
    logic [1:0]        o_dbg_state;

    always #5 i_clk = ~i_clk;

    vram_line_fetch_arbiter #(
        .ADDR_W(AW), .SCREEN_BASE(BASE), .WORDS_PER_LINE(WPL),
        .V_ROWS(VR), .FETCH_LEAD(LEAD)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pix_stb(i_pix_stb),
        .i_clks_before_active(i_clks_before_active), .i_y(i_y),
        .i_cpu_req(i_cpu_req), .i_cpu_we(i_cpu_we), .i_cpu_addr(i_cpu_addr),
        .i_cpu_wdata(i_cpu_wdata), .o_cpu_ack(o_cpu_ack), .o_cpu_rdata(o_cpu_rdata),
        .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
        .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
        .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_wdata(o_lb_wdata),
        .o_line_ready(o_line_ready), .o_underrun(o_underrun), .o_dbg_state(o_dbg_state)
    );

    // ---------------- reference memory and scoreboard ----------------
    logic [15:0]      mem [0:(1<<AW)-1];
    logic [EW-1:0]    exp_mem_q [$];
    logic [LBW+15:0]  exp_lb_q [$];
    logic [16:0]      exp_cpu_q [$];   // {is_read, rdata}

    int pass_cnt = 0;
    int total_cnt = 0;
    int cyc = 0;

    int mem_dly = 1;
    int rst_gen = 0;

    int mem_txn_cnt = 0, lb_cnt = 0, ur_cnt = 0, lb_after_ur = 0;
    int last_ack_cyc = -10, last_lb_cyc = -10, trig_cyc = -10, dl_cyc = -10;
    bit first_fetch_chk = 0, ur_flag = 0;
    logic prev_req = 1'b0, prev_ready = 1'b0;
    logic [AW+16:0] cur_txn = '0;
    logic [EW-1:0]   me;
    logic [LBW+15:0] le;
    logic [16:0]     ce;

    always @(posedge i_clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic fail_now(input string name);
        total_cnt++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Expected transactions for fetching a whole row, from the address rule.
    task automatic push_fetch(input int y);
        logic [AW-1:0]  a;
        logic [LBW-1:0] k5;
        for (int k = 0; k < WPL; k++) begin
            a  = AW'(BASE + y * WPL + k);
            k5 = LBW'(k);
            exp_mem_q.push_back({1'b0, 1'b0, a, 16'h0000});
            exp_lb_q.push_back({k5, mem[a]});
        end
    endtask

    // ---------------- memory responder ----------------
    initial begin
        int g, d;
        forever begin
            @(negedge i_clk);
            if (i_rst_n && o_mem_req) begin
                g = rst_gen;
                d = mem_dly;
                repeat (d) @(posedge i_clk);
                #1;
                if (g == rst_gen && i_rst_n && o_mem_req) begin
                    i_mem_ack   = 1'b1;
                    i_mem_rdata = mem[o_mem_addr];
                    if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
                    @(posedge i_clk);
                    #1;
                    i_mem_ack   = 1'b0;
                    i_mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_mem_req && !prev_req) begin
                mem_txn_cnt++;
                cur_txn = {o_mem_we, o_mem_addr, o_mem_wdata};
                if (exp_mem_q.size() == 0) fail_now("mem_txn_unexpected");
                else begin
                    me = exp_mem_q.pop_front();
                    if (me[EW-1]) check("cpu_mem_txn", cur_txn, me[EW-2:0]);
                    else check("fetch_addr", {o_mem_we, o_mem_addr}, me[EW-2:16]);
                end
                if (first_fetch_chk) begin
                    check("fetch_req_latency", cyc - trig_cyc, 2);
                    first_fetch_chk = 0;
                end
            end
            if (i_mem_ack) begin
                last_ack_cyc = cyc;
                check("mem_stable", {o_mem_we, o_mem_addr, o_mem_wdata}, cur_txn);
            end
            if (o_cpu_ack) begin
                check("cpu_ack_with_mem_ack", i_mem_ack, 1'b1);
                if (exp_cpu_q.size() == 0) fail_now("cpu_ack_unexpected");
                else begin
                    ce = exp_cpu_q.pop_front();
                    if (ce[16]) begin
                        check("cpu_rdata", o_cpu_rdata, ce[15:0]);
                        check("cpu_rdata_pass", o_cpu_rdata, i_mem_rdata);
                    end
                end
            end
            if (o_lb_we) begin
                lb_cnt++;
                if (ur_flag) lb_after_ur++;
                check("lb_we_latency", cyc - last_ack_cyc, 1);
                if (exp_lb_q.size() == 0) fail_now("lb_write_unexpected");
                else begin
                    le = exp_lb_q.pop_front();
                    check("lb_write", {o_lb_addr, o_lb_wdata}, le);
                end
                last_lb_cyc = cyc;
            end
            if (o_underrun) begin
                ur_cnt++;
                ur_flag = 1;
                check("underrun_timing", cyc, dl_cyc + 1);
            end
            if (o_line_ready && !prev_ready)
                check("ready_after_last_lb", cyc - last_lb_cyc, 1);
        end
        prev_req   = o_mem_req;
        prev_ready = o_line_ready;
    end

    // ---------------- drivers ----------------
    // One line of the video generator: counts clks_before_active down from
    // just above FETCH_LEAD to -tail, one step per pixel strobe.
    task automatic run_line(input int y, input int div, input int tail, input bit exp_ready);
        int c  = LEAD + 3;
        int ph = 0;
        i_y = 10'(y);
        while (c >= -tail) begin
            @(posedge i_clk);
            #1;
            i_pix_stb = (ph == 0);
            i_clks_before_active = 10'(c);
            if (ph == 0) begin
                if (c == LEAD && y < VR) begin
                    push_fetch(y);
                    trig_cyc = cyc;
                    first_fetch_chk = 1;
                    ur_flag = 0;
                end
                if (c == 0) begin
                    dl_cyc = cyc;
                    @(negedge i_clk);
                    check("line_ready_at_deadline", o_line_ready, exp_ready);
                end
                c--;
            end
            ph = (ph + 1) % div;
        end
        @(posedge i_clk);
        #1;
        i_pix_stb = 1'b0;
        i_clks_before_active = '0;
    endtask

    task automatic cpu_access(input bit we, input logic [AW-1:0] a, input logic [15:0] d);
        int budget = 600;
        bit done = 0;
        exp_mem_q.push_back({1'b1, we, a, d});
        exp_cpu_q.push_back({!we, mem[a]});
        @(posedge i_clk);
        #1;
        i_cpu_req = 1'b1; i_cpu_we = we; i_cpu_addr = a; i_cpu_wdata = d;
        while (!done && budget > 0) begin
            @(negedge i_clk);
            if (o_cpu_ack) done = 1;
            budget--;
        end
        if (!done) fail_now("cpu_ack_timeout");
        @(posedge i_clk);
        #1;
        i_cpu_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n_txn0, n_lb0, n_ur0, n_wr, n_rd, w, row;
        for (int i = 0; i < (1 << AW); i++) mem[i] = 16'($urandom);

        // reset values while held in reset
        repeat (3) @(posedge i_clk);
        #1;
        check("rst_mem_req", o_mem_req, 1'b0);
        check("rst_mem_we", o_mem_we, 1'b0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_mem_wdata", o_mem_wdata, 0);
        check("rst_lb_we", o_lb_we, 1'b0);
        check("rst_lb_addr", o_lb_addr, 0);
        check("rst_lb_wdata", o_lb_wdata, 0);
        check("rst_line_ready", o_line_ready, 1'b0);
        check("rst_underrun", o_underrun, 1'b0);
        check("rst_state", o_dbg_state, 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (2) @(posedge i_clk);

        // row gating: row beyond V_ROWS gets no fetch
        n_txn0 = mem_txn_cnt;
        run_line(300, 1, 3, 1'b0);
        check("gated_no_fetch", mem_txn_cnt - n_txn0, 0);

        // single row fetch, row 5, ack one cycle after each request
        mem_dly = 1;
        n_lb0 = lb_cnt; n_ur0 = ur_cnt;
        run_line(5, 1, 3, 1'b1);
        repeat (5) @(posedge i_clk);
        check("row5_lb_count", lb_cnt - n_lb0, WPL);
        check("row5_no_underrun", ur_cnt - n_ur0, 0);
        check("row5_mem_q_empty", exp_mem_q.size(), 0);

        // CPU write in idle, then read it back
        cpu_access(1'b1, 15'h4010, 16'hBEEF);
        cpu_access(1'b0, 15'h4010, 16'h1234);

        // CPU read issued mid-fetch waits for the whole row
        row = $urandom_range(0, VR - 1);
        fork
            run_line(row, 1, 3, 1'b1);
            begin
                repeat (20) @(posedge i_clk);
                cpu_access(1'b0, AW'($urandom_range(0, BASE - 1)), 16'($urandom));
            end
        join
        repeat (5) @(posedge i_clk);

        // random CPU traffic with random memory latency, then random rows
        for (int it = 0; it < 3; it++) begin
            mem_dly = $urandom_range(1, 4);
            for (int j = 0; j < 3; j++)
                cpu_access(1'($urandom_range(0, 1)), AW'($urandom_range(0, BASE - 1)), 16'($urandom));
            mem_dly = 1;
            run_line($urandom_range(0, VR - 1), 1, 3, 1'b1);
            repeat (4) @(posedge i_clk);
        end
        check("rand_cpu_q_empty", exp_cpu_q.size(), 0);

        // underrun: slow memory, pixel strobe every 2 clocks
        mem_dly = 20;
        n_wr = 0; n_rd = 0;
        for (int k = 0; k < WPL; k++) begin
            if (2 + k * (mem_dly + 2) + mem_dly <= 2 * LEAD) n_wr++;
            if (2 + k * (mem_dly + 2) <= 2 * LEAD) n_rd++;
        end
        n_txn0 = mem_txn_cnt; n_lb0 = lb_cnt; n_ur0 = ur_cnt; lb_after_ur = 0;
        run_line(9, 2, 2, 1'b0);
        repeat (40) @(posedge i_clk);
        check("ur_pulse_count", ur_cnt - n_ur0, 1);
        check("ur_lb_count", lb_cnt - n_lb0, n_wr);
        check("ur_read_count", mem_txn_cnt - n_txn0, n_rd);
        check("ur_no_lb_after", lb_after_ur, 0);
        check("ur_line_not_ready", o_line_ready, 1'b0);
        exp_mem_q.delete();
        exp_lb_q.delete();

        // reset in the middle of a fetch transfer
        mem_dly = 30;
        @(posedge i_clk);
        #1;
        i_y = 10'd12; i_pix_stb = 1'b1; i_clks_before_active = 10'(LEAD);
        push_fetch(12);
        trig_cyc = cyc;
        first_fetch_chk = 1;
        @(posedge i_clk);
        #1;
        i_pix_stb = 1'b0;
        w = 0;
        while (!o_mem_req && w < 10) begin
            @(negedge i_clk);
            w++;
        end
        check("rst_test_fetch_started", o_mem_req, 1'b1);
        repeat (5) @(negedge i_clk);
        #2;
        i_rst_n = 1'b0;
        rst_gen++;
        #1;
        check("async_rst_mem_req", o_mem_req, 1'b0);
        check("async_rst_state", o_dbg_state, 0);
        exp_mem_q.delete();
        exp_lb_q.delete();
        first_fetch_chk = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        mem_dly = 1;
        cpu_access(1'b0, AW'($urandom_range(0, BASE - 1)), 16'($urandom));
        repeat (5) @(posedge i_clk);
        check("end_mem_q_empty", exp_mem_q.size(), 0);
        check("end_cpu_q_empty", exp_cpu_q.size(), 0);
        check("end_no_lb_after_reset", exp_lb_q.size(), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", pass_cnt, total_cnt + 1);
        $fatal(1, "watchdog");
    end

endmodule
